// File: rtl/u109_pci_cycle_ctrl.sv
// U109 PCI cycle sequencer: maps 68040 transfers onto PCI address/data phases.
// Optional build macro U109_PCI_TURNAROUND_EN adds a PCIDIR turnaround cycle in TERM.
module u109_pci_cycle_ctrl #(
    parameter int unsigned BURST_BEATS    = 4,
    parameter int unsigned ALATCH_CYCLES  = 1,
    parameter int unsigned DEVSEL_TIMEOUT = 6,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic       CLK40,
    input  logic       RESETn,
    input  logic       TSn,
    input  logic       RnW,
    input  logic [1:0] SIZ,
    input  logic       PCISEL,
    input  logic       DEVSELn,
    input  logic       TRDYn,
    input  logic       STOPn,
    output logic       PCICYCLEn,
    output logic       PCIDIR,
    output logic       ALATCH,
    output logic       ADLATCH,
    output logic       TAn,
    output logic       TEAn
);

    typedef enum logic [2:0] {
        StIdle, StAddr, StClaim, StData, StAck, StRetry, StErr, StTerm
    } state_e;

    state_e     r_state, w_state_d;
    logic [3:0] r_beats, w_beats_d;
    logic [2:0] r_retry, w_retry_d;
    logic [3:0] r_tmo, w_tmo_d;
    logic [1:0] r_acnt, w_acnt_d;
    logic       r_dir, w_dir_d;
`ifdef U109_PCI_TURNAROUND_EN
    logic       r_term, w_term_d;
`endif

    logic r_pcicyclen, r_pcidir, r_alatch, r_adlatch, r_tan, r_tean;
    logic w_pcicyclen, w_pcidir, w_alatch, w_adlatch, w_tan, w_tean;

    always_comb begin
        w_state_d = r_state;
        w_beats_d = r_beats;
        w_retry_d = r_retry;
        w_tmo_d   = r_tmo;
        w_acnt_d  = r_acnt;
        w_dir_d   = r_dir;
`ifdef U109_PCI_TURNAROUND_EN
        w_term_d  = 1'b0;
`endif
        case (r_state)
            StIdle: begin
                if (!TSn && PCISEL) begin
                    w_state_d = StAddr;
                    w_dir_d   = ~RnW;
                    w_beats_d = (SIZ == 2'b11) ? 4'(BURST_BEATS) : 4'd1;
                    w_retry_d = 3'(MAX_RETRY);
                    w_acnt_d  = 2'(ALATCH_CYCLES);
                end
            end
            StAddr: begin
                if (r_acnt == 2'd1) begin
                    w_state_d = StClaim;
                    w_tmo_d   = 4'(DEVSEL_TIMEOUT);
                end else begin
                    w_acnt_d = r_acnt - 2'd1;
                end
            end
            StClaim: begin
                if (!DEVSELn && !TRDYn) begin
                    w_state_d = StAck;
                end else if (!STOPn) begin
                    w_state_d = StRetry;
                end else if (!DEVSELn) begin
                    w_state_d = StData;
                end else if (r_tmo == 4'd1) begin
                    w_state_d = StErr;
                end else begin
                    w_tmo_d = r_tmo - 4'd1;
                end
            end
            StData: begin
                if (!TRDYn) begin
                    w_state_d = StAck;
                end else if (!STOPn) begin
                    w_state_d = StRetry;
                end
            end
            StAck: begin
                w_beats_d = r_beats - 4'd1;
                w_state_d = (r_beats == 4'd1) ? StTerm : StData;
            end
            StRetry: begin
                // Remaining beats are kept, so acknowledged data is never repeated.
                if (r_retry != 3'd0) begin
                    w_retry_d = r_retry - 3'd1;
                    w_acnt_d  = 2'(ALATCH_CYCLES);
                    w_state_d = StAddr;
                end else begin
                    w_state_d = StErr;
                end
            end
            StErr: w_state_d = StTerm;
            StTerm: begin
`ifdef U109_PCI_TURNAROUND_EN
                if (!r_term) begin
                    w_term_d = 1'b1;
                end else begin
                    w_state_d = StIdle;
                end
`else
                w_state_d = StIdle;
`endif
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they track the state register.
    always_comb begin
        w_pcicyclen = 1'b1;
        w_pcidir    = 1'b0;
        w_alatch    = 1'b0;
        w_adlatch   = 1'b0;
        w_tan       = 1'b1;
        w_tean      = 1'b1;
        case (w_state_d)
            StAddr: begin
                w_pcicyclen = 1'b0;
                w_alatch    = 1'b1;
                w_pcidir    = w_dir_d;
            end
            StClaim, StData: begin
                w_pcicyclen = 1'b0;
                w_pcidir    = w_dir_d;
            end
            StAck: begin
                w_pcicyclen = 1'b0;
                w_pcidir    = w_dir_d;
                w_adlatch   = 1'b1;
                w_tan       = 1'b0;
            end
            StRetry: w_pcidir = w_dir_d;
            StErr: begin
                w_tean = 1'b0;
`ifdef U109_PCI_TURNAROUND_EN
                w_pcidir = w_dir_d;
`endif
            end
            StTerm: begin
`ifdef U109_PCI_TURNAROUND_EN
                w_pcidir = w_term_d ? 1'b0 : w_dir_d;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK40 or negedge RESETn) begin
        if (!RESETn) begin
            r_state     <= StIdle;
            r_beats     <= 4'd0;
            r_retry     <= 3'd0;
            r_tmo       <= 4'd0;
            r_acnt      <= 2'd0;
            r_dir       <= 1'b0;
`ifdef U109_PCI_TURNAROUND_EN
            r_term      <= 1'b0;
`endif
            r_pcicyclen <= 1'b1;
            r_pcidir    <= 1'b0;
            r_alatch    <= 1'b0;
            r_adlatch   <= 1'b0;
            r_tan       <= 1'b1;
            r_tean      <= 1'b1;
        end else begin
            r_state     <= w_state_d;
            r_beats     <= w_beats_d;
            r_retry     <= w_retry_d;
            r_tmo       <= w_tmo_d;
            r_acnt      <= w_acnt_d;
            r_dir       <= w_dir_d;
`ifdef U109_PCI_TURNAROUND_EN
            r_term      <= w_term_d;
`endif
            r_pcicyclen <= w_pcicyclen;
            r_pcidir    <= w_pcidir;
            r_alatch    <= w_alatch;
            r_adlatch   <= w_adlatch;
            r_tan       <= w_tan;
            r_tean      <= w_tean;
        end
    end

    assign PCICYCLEn = r_pcicyclen;
    assign PCIDIR    = r_pcidir;
    assign ALATCH    = r_alatch;
    assign ADLATCH   = r_adlatch;
    assign TAn       = r_tan;
    assign TEAn      = r_tean;

endmodule

// File: doc/u109_pci_cycle_ctrl.md
Name: u109_pci_cycle_ctrl

Overview:
Parametrised PCI cycle sequencer for U109 on the AmigaPCI board. It replaces the static tie-offs on PCICYCLEn, PCIDIR, ALATCH and ADLATCH with a real state machine. The block sequences 68040-side transfers decoded to PCI space into PCI address/data phases, and generates the buffer direction and latch strobes. It also returns TAn/TEAn to the CPU, supports line bursts, handles target retry and enforces a DEVSEL timeout.

Parameters:
BURST_BEATS, 4, data beats for a line transfer (SIZ=2'b11); range 2..8
ALATCH_CYCLES, 1, CLK40 cycles ALATCH is held high in the address phase; range 1..3
DEVSEL_TIMEOUT, 6, cycles after the address phase to wait for DEVSELn before master abort; range 3..15
MAX_RETRY, 3, STOPn retries before the transfer ends in TEAn; range 0..7

Ports:
CLK40  in  1  system clock; all logic rising-edge
RESETn  in  1  asynchronous active-low reset
TSn  in  1  68040 transfer start, low for one cycle
RnW  in  1  1=read, 0=write
SIZ  in  2  68040 size; 2'b11 = line burst
PCISEL  in  1  address decoded to PCI space, valid with TSn
DEVSELn  in  1  PCI target claim, pre-synchronised
TRDYn  in  1  PCI target ready, pre-synchronised
STOPn  in  1  PCI target stop, pre-synchronised
PCICYCLEn  out  1  low while a PCI cycle is owned
PCIDIR  out  1  data buffer direction; 1 = Amiga drives PCI (write)
ALATCH  out  1  address latch enable
ADLATCH  out  1  data latch/advance strobe, one cycle per beat
TAn  out  1  transfer acknowledge to CPU, one cycle per beat
TEAn  out  1  transfer error to CPU, one cycle

Behaviour:
- Reset (async, RESETn=0): PCICYCLEn=1, PCIDIR=0, ALATCH=0, ADLATCH=0, TAn=1, TEAn=1. State=IDLE. Beat, timeout and retry counters are cleared. Reset mid-cycle aborts immediately with no TAn/TEAn.
- All outputs are registered. No combinational path from inputs to outputs.
- States: IDLE, ADDR, CLAIM, DATA, ACK, RETRY, ERR, TERM.
- IDLE:
  - TSn=0 && PCISEL=1 -> ADDR.
  - Latch RnW. Load beats = (SIZ==2'b11) ? BURST_BEATS : 1.
  - Load retry counter = MAX_RETRY.
  - TSn with PCISEL=0 is ignored.
- ADDR:
  - PCICYCLEn=0, ALATCH=1 for ALATCH_CYCLES cycles, PCIDIR=~RnW_latched.
  - Then -> CLAIM with the timeout counter = DEVSEL_TIMEOUT.
- CLAIM:
  - DEVSELn=0 and TRDYn=0 -> ACK.
  - DEVSELn=0 and TRDYn=1 -> DATA.
  - STOPn=0 with TRDYn=1 -> RETRY.
  - Counter reaches 0 with DEVSELn=1 -> ERR.
  - Priority: TRDYn > STOPn > timeout.
- DATA: wait for TRDYn=0 -> ACK. STOPn=0 with TRDYn=1 -> RETRY. No timeout once claimed.
- ACK:
  - One cycle with ADLATCH=1 and TAn=0. Decrement beats.
  - beats now 0 -> TERM. Otherwise -> DATA.
  - Latency: TRDYn sampled low in cycle N gives TAn/ADLATCH in cycle N+1.
- RETRY:
  - PCICYCLEn=1 for one cycle.
  - Retry counter > 0: decrement it and re-enter ADDR for the remaining beats.
  - Retry counter = 0: -> ERR.
  - Beats already acknowledged are not repeated.
- ERR: TEAn=0 for one cycle, PCICYCLEn=1 -> TERM.
- TERM: PCICYCLEn=1, PCIDIR=0 -> IDLE next cycle.
- TSn while not in IDLE is ignored; the 68040 does not issue it while awaiting TA/TEA.
- TAn and TEAn are never low in the same cycle.

Optional Feature:
U109_PCI_TURNAROUND_EN
- Defined: TERM holds PCIDIR at its cycle value for one extra cycle after PCICYCLEn rises, then drives 0. A TSn arriving in that cycle is ignored. This guarantees a bus turnaround cycle.
- Undefined: PCIDIR returns to 0 in the same cycle PCICYCLEn rises, and TERM lasts one cycle.

Test Plan:
- Single read: TSn=0, PCISEL=1, RnW=1, SIZ=00; DEVSELn low at +2, TRDYn low at +3 -> ALATCH high 1 cycle, PCIDIR=0, exactly one TAn and one ADLATCH, PCICYCLEn low until TERM.
- Write burst: SIZ=11, RnW=0, TRDYn low on beats with 0/2/0/1 wait cycles -> PCIDIR=1 throughout, 4 TAn pulses each one cycle after TRDYn, then PCICYCLEn=1.
- Master abort: DEVSELn held high -> TEAn low 1 cycle after DEVSEL_TIMEOUT=6 cycles in CLAIM, no TAn, PCICYCLEn=1.
- Retry: STOPn low after beat 2 of a 4-beat burst, MAX_RETRY=3 -> PCICYCLEn high 1 cycle, new ALATCH, only 2 further TAn; STOPn on 4 consecutive attempts -> TEAn.
- Reset mid-burst: RESETn low during DATA -> all outputs to reset values asynchronously, no TAn/TEAn; the next TSn starts a clean ADDR.
- Turnaround (both builds): back-to-back write then read -> with macro, PCIDIR=1 for one cycle after PCICYCLEn rises and a TSn in that cycle is ignored; without it, PCIDIR=0 in the same cycle.
